// File: rtl/seg_pkg.sv
// Shared seven-segment pattern constants, active-low {dp,g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [7:0] Seg0     = 8'hC0;
  localparam logic [7:0] Seg1     = 8'hF9;
  localparam logic [7:0] Seg2     = 8'hA4;
  localparam logic [7:0] Seg3     = 8'hB0;
  localparam logic [7:0] Seg4     = 8'h99;
  localparam logic [7:0] Seg5     = 8'h92;
  localparam logic [7:0] Seg6     = 8'h82;
  localparam logic [7:0] Seg7     = 8'hF8;
  localparam logic [7:0] Seg8     = 8'h80;
  localparam logic [7:0] Seg9     = 8'h90;
  localparam logic [7:0] SegDash  = 8'hBF;
  localparam logic [7:0] SegBlank = 8'hFF;

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD-to-segment decode; non-BCD codes show a dash.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SegDash;
    case (digit_i)
      4'd0:    seg_o = Seg0;
      4'd1:    seg_o = Seg1;
      4'd2:    seg_o = Seg2;
      4'd3:    seg_o = Seg3;
      4'd4:    seg_o = Seg4;
      4'd5:    seg_o = Seg5;
      4'd6:    seg_o = Seg6;
      4'd7:    seg_o = Seg7;
      4'd8:    seg_o = Seg8;
      4'd9:    seg_o = Seg9;
      default: seg_o = SegDash;
    endcase
  end

endmodule

// File: rtl/seg_disp_scan.sv
// Multiplexed seven-segment scanner for NUM BCD digits.
// Optional leading-zero blanking is enabled by defining SEG_LEAD_ZERO_BLANK_EN.
module seg_disp_scan
  import seg_pkg::*;
#(
  parameter int unsigned NUM      = 3,
  parameter int unsigned SCAN_CNT = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4*NUM-1:0]  din,
  input  logic              din_vld,
  output logic [NUM-1:0]    seg_sel,
  output logic [7:0]        seg_ment
);

  localparam int unsigned CntW = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
  localparam int unsigned IdxW = (NUM > 1) ? $clog2(NUM) : 1;

  logic [4*NUM-1:0] data_q, data_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [NUM-1:0]   seg_sel_q, seg_sel_d;
  logic [7:0]       seg_ment_q, seg_ment_d;

  logic       cnt_wrap;
  logic [3:0] digit;
  logic [7:0] dec_seg;

  always_comb begin
    cnt_wrap = (cnt_q == CntW'(SCAN_CNT - 1));
    data_d   = din_vld ? din : data_q;
    cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IdxW'(NUM - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    digit = 4'd0;
    for (int k = 0; k < NUM; k++) begin
      if (idx_q == IdxW'(k)) digit = data_q[4*k +: 4];
    end
  end

  seg_decode u_seg_decode (
    .digit_i (digit),
    .seg_o   (dec_seg)
  );

`ifdef SEG_LEAD_ZERO_BLANK_EN
  logic blank;
  logic nz_hi;

  // Walk down from the top digit; blank the active digit while nothing at or above it is nonzero.
  always_comb begin
    blank = 1'b0;
    nz_hi = 1'b0;
    for (int k = NUM - 1; k >= 1; k--) begin
      nz_hi = nz_hi | (data_q[4*k +: 4] != 4'd0);
      if ((idx_q == IdxW'(k)) && !nz_hi) blank = 1'b1;
    end
  end

  always_comb begin
    seg_sel_d  = ~(NUM'(1) << idx_q);
    seg_ment_d = blank ? SegBlank : dec_seg;
  end
`else
  always_comb begin
    seg_sel_d  = ~(NUM'(1) << idx_q);
    seg_ment_d = dec_seg;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      seg_sel_q  <= '1;
      seg_ment_q <= SegBlank;
    end else begin
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      seg_sel_q  <= seg_sel_d;
      seg_ment_q <= seg_ment_d;
    end
  end

  assign seg_sel  = seg_sel_q;
  assign seg_ment = seg_ment_q;

endmodule

// File: tb/tb_seg_disp_scan.sv
// Directed bench for seg_disp_scan with NUM=3, SCAN_CNT=4.
module tb_seg_disp_scan;

  localparam int unsigned NUM      = 3;
  localparam int unsigned SCAN_CNT = 4;

`ifdef SEG_LEAD_ZERO_BLANK_EN
  localparam logic [7:0] Lz = 8'hFF;
`else
  localparam logic [7:0] Lz = 8'hC0;
`endif

  logic              clk;
  logic              rst_n;
  logic [4*NUM-1:0]  din;
  logic              din_vld;
  logic [NUM-1:0]    seg_sel;
  logic [7:0]        seg_ment;

  int n_cmp = 0;
  int n_err = 0;

  seg_disp_scan #(
    .NUM      (NUM),
    .SCAN_CNT (SCAN_CNT)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_vld  (din_vld),
    .seg_sel  (seg_sel),
    .seg_ment (seg_ment)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, act, exp);
    end
  endtask

  // Advance n edges, checking both outputs 1 time unit after each edge.
  task automatic run_slot(input string tag, input logic [2:0] sel, input logic [7:0] ment,
                          input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("%s[%0d].sel", tag, i), {5'b0, seg_sel}, {5'b0, sel});
      check_val($sformatf("%s[%0d].ment", tag, i), seg_ment, ment);
    end
  endtask

  task automatic load(input logic [11:0] val);
    din     = val;
    din_vld = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    din     = '0;
    din_vld = 1'b0;
    #1;

    run_slot("rst", 3'b111, 8'hFF, 3);

    // First edge out of reset shows digit 0 of the cleared shadow register.
    rst_n = 1'b1;
    load(12'h123);
    run_slot("first", 3'b110, 8'hC0, 1);
    din_vld = 1'b0;
    run_slot("d123_0", 3'b110, 8'hB0, 3);
    run_slot("d123_1", 3'b101, 8'hA4, 4);
    run_slot("d123_2", 3'b011, 8'hF9, 4);
    run_slot("d123_wrap", 3'b110, 8'hB0, 4);

    load(12'h00A);
    run_slot("d00a_ld", 3'b101, 8'hA4, 1);
    din_vld = 1'b0;
    run_slot("d00a_1", 3'b101, Lz, 3);
    run_slot("d00a_2", 3'b011, Lz, 4);
    run_slot("d00a_0", 3'b110, 8'hBF, 4);

    din = 12'h456;
    run_slot("hold_1", 3'b101, Lz, 4);
    run_slot("hold_2", 3'b011, Lz, 4);
    run_slot("hold_0", 3'b110, 8'hBF, 4);

    load(12'h007);
    run_slot("d007_ld", 3'b101, Lz, 1);
    din_vld = 1'b0;
    run_slot("d007_1", 3'b101, Lz, 3);
    run_slot("d007_2", 3'b011, Lz, 4);
    run_slot("d007_0", 3'b110, 8'hF8, 4);

    load(12'h000);
    run_slot("d000_ld", 3'b101, Lz, 1);
    din_vld = 1'b0;
    run_slot("d000_1", 3'b101, Lz, 3);
    run_slot("d000_2", 3'b011, Lz, 4);
    run_slot("d000_0", 3'b110, 8'hC0, 4);

    load(12'h050);
    run_slot("d050_ld", 3'b101, Lz, 1);
    din_vld = 1'b0;
    run_slot("d050_1", 3'b101, 8'h92, 3);
    run_slot("d050_2", 3'b011, Lz, 4);
    run_slot("d050_0", 3'b110, 8'hC0, 4);
    run_slot("d050_1b", 3'b101, 8'h92, 3);

    // Load on the same edge the slot advances to digit 2.
    load(12'h987);
    run_slot("slot_ld", 3'b101, 8'h92, 1);
    din_vld = 1'b0;
    run_slot("d987_2", 3'b011, 8'h90, 4);
    run_slot("d987_0", 3'b110, 8'hF8, 4);
    run_slot("d987_1", 3'b101, 8'h80, 4);
    run_slot("d987_2b", 3'b011, 8'h90, 1);

    // Now idx=2, cnt=1: reset for one edge abandons the slot.
    rst_n = 1'b0;
    run_slot("rst_mid", 3'b111, 8'hFF, 1);
    rst_n = 1'b1;
    run_slot("post_rst_0", 3'b110, 8'hC0, 4);
    run_slot("post_rst_1", 3'b101, Lz, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_disp_scan.md
SEG_DISP_SCAN -- requirements
Module: seg_disp_scan

Interface
REQ-001 The block SHALL have parameter NUM, default 3, meaning the number of BCD digits displayed.
REQ-002 The block SHALL have parameter SCAN_CNT, default 50000, meaning clocks per digit time slot (min 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port din, input, 4*NUM bits: BCD digits; digit k occupies bits [4k+3:4k], and digit 0 is least significant.
REQ-006 The block SHALL have port din_vld, input, 1 bit: din is valid this cycle; no backpressure.
REQ-007 The block SHALL have port seg_sel, output, NUM bits: digit select, active-low and one-hot-low.
REQ-008 The block SHALL have port seg_ment, output, 8 bits: segments {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-009 The block SHALL load din into an internal shadow register data_reg at an edge where din_vld=1, and SHALL hold data_reg otherwise.
REQ-010 The scan timer cnt SHALL count 0..SCAN_CNT-1 and wrap; at cnt=SCAN_CNT-1, digit index idx SHALL advance by 1, wrapping from NUM-1 to 0.
REQ-011 seg_sel and seg_ment SHALL be registered and SHALL change at the same edge; seg_sel SHALL equal ~(1<<idx).
REQ-012 seg_ment SHALL show the decode of data_reg digit idx one edge after idx or data_reg changes.
REQ-013 Overall latency SHALL be: din_vld sampled at edge t gives the new pattern on seg_ment after edge t+1 if that digit is active.
REQ-014 Decode SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex); dp is always off.
REQ-015 A digit value of 10..15 SHALL display dash BF.
REQ-016 When din_vld=1 on the same edge as a slot change, the new idx SHALL display the new data.
REQ-017 With SCAN_CNT=1, idx SHALL advance every clock.

Reset
REQ-018 While rst_n=0 at an edge: data_reg=0, cnt=0, idx=0, seg_sel=all ones, seg_ment=FF.
REQ-019 At the first edge with rst_n=1: seg_sel SHALL be ~1, and seg_ment SHALL show digit 0 of data_reg.
REQ-020 Reset mid-scan SHALL abandon the current slot without completing it.

Configuration
REQ-021 With macro SEG_LEAD_ZERO_BLANK_EN defined:
- Every digit more significant than the highest nonzero digit of data_reg SHALL output seg_ment=FF; seg_sel still scans normally.
- Digit 0 SHALL never be blanked.
- Digits 10..15 SHALL count as nonzero.
REQ-022 With SEG_LEAD_ZERO_BLANK_EN undefined, every digit SHALL be decoded per REQ-014/015, and no blanking logic SHALL exist.

Structure
REQ-023 Segment pattern constants (0-9, DASH, BLANK) SHALL live in shared package seg_pkg.
REQ-024 The BCD-to-segment decode SHALL be a combinational sub-module seg_decode (4-bit in, 8-bit out), instantiated once on the muxed digit.

Verification (NUM=3, SCAN_CNT=4)
REQ-025 The bench SHALL cover: hold rst_n=0 for 3 clocks -> seg_sel=111, seg_ment=FF every cycle.
REQ-026 The bench SHALL cover: din=123 with a 1-cycle din_vld pulse, macro off -> seg_sel 110/101/011 for 4 clocks each, with seg_ment B0/A4/F9, then wrap to 110/B0.
REQ-027 The bench SHALL cover: din=00A with din_vld -> digit 0 shows BF; digits 1 and 2 show C0.
REQ-028 The bench SHALL cover: din changes to 456 with din_vld=0 -> the display is unchanged from the prior latched value.
REQ-029 The bench SHALL cover blanking:
- Macro on, din=007 -> digits 2 and 1 show FF, digit 0 shows F8.
- Macro on, din=000 -> digit 0 shows C0.
- Macro off, din=007 -> digits 2 and 1 show C0.
REQ-030 The bench SHALL cover: assert rst_n=0 for 1 edge while idx=2, cnt=1 -> that edge gives 111/FF; the next edge gives 110 with digit 0 decoded from data_reg=0.
